// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - 8-digit multiplexed common-anode 7-segment scanner for BCD time digits
//
// Purpose:
//   Scans the eight BCD time digits onto a multiplexed common-anode display,
//   one digit per DWELL cycles. Adds 24 h / 12 h hour presentation, edit-mode
//   blinking of the hour/minute digits and dash display of invalid digits.
//   The digits are captured once per frame so a display frame never mixes
//   old and new time values.
//
// Ports:
//   clk_1kHz    system clock, 1 kHz tick
//   reset       synchronous, active-high
//   mode        00 = 24 h, 01 = 12 h, 10/11 = raw digit display
//   edit        time-set mode active (blinks idx7..4 in modes 00/01)
//   h1..k1      BCD digit nibbles, idx7 = h1 ... idx0 = k1
//   an          digit enables, active-low, an[7] = leftmost digit
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse on each snapshot load

module seg_display_scan #(
    parameter int DWELL      = 2,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk_1kHz,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       edit,
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    input  logic [3:0] k2,
    input  logic [3:0] k1,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int                 BLINK_W    = $clog2(2 * BLINK_HALF + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_MID  = BLINK_W'(BLINK_HALF);
    localparam logic [7:0]         DWELL_LAST = 8'(DWELL - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [2:0]         scan_idx;
    logic [7:0]         dwell_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [31:0]        snapshot;
    logic [31:0]        live_digits;

    // Packed so that nibble n of the vector is display index n.
    assign live_digits = {h1, h0, m1, m0, s1, s0, k2, k1};

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] code;
        case (v)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Hour interpretation of the snapshot
    // ------------------------------------------------------------------
    logic [3:0] snap_h1;
    logic [3:0] snap_h0;
    logic [7:0] hours;
    logic [7:0] hours12;
    logic [7:0] hours12_lo;
    logic       hours_bad;
    logic       pm_hour;
    logic [3:0] disp_h1;
    logic [3:0] disp_h0;

    always_comb begin
        snap_h1    = snapshot[31:28];
        snap_h0    = snapshot[27:24];
        hours      = ({4'd0, snap_h1} * 8'd10) + {4'd0, snap_h0};
        hours_bad  = (snap_h1 > 4'd9) || (snap_h0 > 4'd9) || (hours > 8'd23);
        pm_hour    = (hours >= 8'd12);
        hours12    = pm_hour ? (hours - 8'd12) : hours;
        if (hours12 == 8'd0) begin
            hours12 = 8'd12;
        end
        hours12_lo = hours12 - 8'd10;
        if (hours12 >= 8'd10) begin
            disp_h1 = 4'd1;
            disp_h0 = hours12_lo[3:0];
        end else begin
            disp_h1 = 4'd0;
            disp_h0 = hours12[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-digit decode of the currently selected index
    // ------------------------------------------------------------------
    logic       clock_mode;
    logic       twelve_mode;
    logic       blink_phase;
    logic       show_pm;
    logic [3:0] nibble;
    logic       digit_blank;
    logic       digit_dash;
    logic       dp_on;
    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    always_comb begin
        clock_mode  = ~mode[1];
        twelve_mode = (mode == 2'b01);
        blink_phase = (blink_cnt >= BLINK_MID);
        show_pm     = twelve_mode && !hours_bad && pm_hour;
        nibble      = snapshot[{scan_idx, 2'b00} +: 4];
        digit_blank = 1'b0;
        digit_dash  = 1'b0;

        // Hour digits are the only ones reinterpreted in clock modes.
        if (clock_mode && (scan_idx[2:1] == 2'b11)) begin
            if (hours_bad) begin
                digit_dash = 1'b1;
            end else if (twelve_mode) begin
                nibble = scan_idx[0] ? disp_h1 : disp_h0;
                // Leading zero of a 12 h hour is suppressed.
                if (scan_idx[0] && (disp_h1 == 4'd0)) begin
                    digit_blank = 1'b1;
                end
            end
        end

        // Edit blinking covers hours and minutes (idx7..4).
        if (clock_mode && edit && blink_phase && scan_idx[2]) begin
            digit_blank = 1'b1;
        end

        dp_on = clock_mode && ((scan_idx == 3'd6) || (scan_idx == 3'd4)
                               || ((scan_idx == 3'd0) && show_pm));

        if (digit_blank) begin
            an_next  = 8'hFF;
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end else begin
            an_next  = ~(8'b0000_0001 << scan_idx);
            seg_next = digit_dash ? SEG_DASH : seg_code(nibble);
            dp_next  = ~dp_on;
        end
    end

    // ------------------------------------------------------------------
    // Scan, blink and snapshot state with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1kHz) begin
        if (reset) begin
            scan_idx   <= 3'd7;
            dwell_cnt  <= 8'd0;
            blink_cnt  <= '0;
            snapshot   <= 32'd0;
            an         <= 8'hFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= 1'b0;

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= 8'd0;
                // 3-bit decrement wraps 0 -> 7 naturally.
                scan_idx  <= scan_idx - 3'd1;
                if (scan_idx == 3'd0) begin
                    snapshot   <= live_digits;
                    frame_tick <= 1'b1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end

endmodule
